// File: rtl/arith_chain_arbiter.sv
// Two-requester round-robin front end for a shared fixed-latency arithmetic chain.
// A requester tag shadows each operand through the chain so the result returns to its owner.
module arith_chain_arbiter #(
  parameter int DATA_WIDTH_IN  = 8,
  parameter int DATA_WIDTH_OUT = 10,
  parameter int LATENCY        = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [DATA_WIDTH_IN-1:0]  req0_data,
  input  logic [DATA_WIDTH_IN-1:0]  req1_data,
  input  logic                      req0_valid,
  input  logic                      req1_valid,
  output logic                      req0_ready,
  output logic                      req1_ready,
  output logic [DATA_WIDTH_IN-1:0]  pipe_data_in,
  output logic                      pipe_valid_in,
  input  logic [DATA_WIDTH_OUT-1:0] pipe_data_out,
  input  logic                      pipe_valid_out,
  output logic [DATA_WIDTH_OUT-1:0] rsp0_data,
  output logic [DATA_WIDTH_OUT-1:0] rsp1_data,
  output logic                      rsp0_valid,
  output logic                      rsp1_valid,
  output logic                      busy,
  output logic                      err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  // Worst case in flight is LATENCY+2 (accept cycle through response cycle).
  localparam int CNT_W = $clog2(LATENCY + 3);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             last_grant;
  logic [CNT_W-1:0] inflight;
  logic             pipe_tag;
  logic             xfer0;
  logic             xfer1;
  logic             xfer;
  logic [LATENCY-1:0] tag_valid;
  logic [LATENCY-1:0] tag_id;
  logic             out_tag_valid;
  logic             out_tag_id;
  logic             deliver;
  logic             mismatch;
  logic             retire;

  // Grant only in RUN; on contention the requester that did not win last time goes first.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == RUN) begin
      if (req0_valid && req1_valid) begin
        req0_ready = last_grant;
        req1_ready = ~last_grant;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  assign xfer0 = req0_valid & req0_ready;
  assign xfer1 = req1_valid & req1_ready;
  assign xfer  = xfer0 | xfer1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant    <= 1'b1;
      pipe_valid_in <= 1'b0;
      pipe_data_in  <= '0;
      pipe_tag      <= 1'b0;
    end else begin
      pipe_valid_in <= xfer;
      if (xfer) begin
        last_grant   <= xfer1;
        pipe_tag     <= xfer1;
        pipe_data_in <= xfer1 ? req1_data : req0_data;
      end
    end
  end

  // Tag shift register: stage LATENCY-1 lines up with pipe_valid_out.
  generate
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_tag
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            tag_valid[gi] <= 1'b0;
            tag_id[gi]    <= 1'b0;
          end else begin
            tag_valid[gi] <= pipe_valid_in;
            tag_id[gi]    <= pipe_tag;
          end
        end
      end else begin : g_rest
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            tag_valid[gi] <= 1'b0;
            tag_id[gi]    <= 1'b0;
          end else begin
            tag_valid[gi] <= tag_valid[gi-1];
            tag_id[gi]    <= tag_id[gi-1];
          end
        end
      end
    end
  endgenerate

  assign out_tag_valid = tag_valid[LATENCY-1];
  assign out_tag_id    = tag_id[LATENCY-1];
  assign deliver       = pipe_valid_out & out_tag_valid;
  assign mismatch      = pipe_valid_out ^ out_tag_valid;
  // A tag leaving the pipe retires its slot whether delivered or dropped, so DRAIN cannot stick.
  assign retire        = out_tag_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
      err        <= 1'b0;
    end else begin
      rsp0_valid <= deliver & ~out_tag_id;
      rsp1_valid <= deliver & out_tag_id;
      if (deliver && !out_tag_id) rsp0_data <= pipe_data_out;
      if (deliver && out_tag_id)  rsp1_data <= pipe_data_out;
      if (mismatch) err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({xfer, retire})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = RUN;
      RUN:     if (!en) state_next = DRAIN;
      DRAIN: begin
        if (en)                  state_next = RUN;
        else if (inflight == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  assign busy = (state != IDLE);

endmodule
